// File: rtl/psum_acc_pkg.sv
// Shared types and default sizes for the partial-sum accumulator.
package psum_acc_pkg;

  localparam int IN_SIZE_DEF  = 21;
  localparam int ACC_SIZE_DEF = 32;
  localparam int CNT_SIZE_DEF = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // Resolved beat held between the resolve and accumulate stages.
  typedef struct packed {
    logic [ACC_SIZE_DEF-1:0] s;
    logic                    first;
    logic                    last;
  } stage_a_t;

endpackage

// File: rtl/psum_accumulator_if.sv
// Input beat and output result handshakes of psum_accumulator.
// ovf_o exists only when PSUM_ACC_SATURATE_EN is defined.
interface psum_accumulator_if
  import psum_acc_pkg::*;
#(
  parameter int IN_SIZE  = IN_SIZE_DEF,
  parameter int ACC_SIZE = ACC_SIZE_DEF,
  parameter int CNT_SIZE = CNT_SIZE_DEF
);
  logic                valid_i;
  logic                ready_o;
  logic [IN_SIZE-1:0]  sum_i;
  logic [IN_SIZE-1:0]  carry_i;
  logic                first_i;
  logic                last_i;
  logic                valid_o;
  logic                ready_i;
  logic [ACC_SIZE-1:0] acc_o;
  logic [CNT_SIZE-1:0] cnt_o;
  logic                restart_o;
`ifdef PSUM_ACC_SATURATE_EN
  logic                ovf_o;
`endif

  modport slave (
    input  valid_i, sum_i, carry_i, first_i, last_i, ready_i,
`ifdef PSUM_ACC_SATURATE_EN
    output ovf_o,
`endif
    output ready_o, valid_o, acc_o, cnt_o, restart_o
  );

  modport master (
    output valid_i, sum_i, carry_i, first_i, last_i, ready_i,
`ifdef PSUM_ACC_SATURATE_EN
    input  ovf_o,
`endif
    input  ready_o, valid_o, acc_o, cnt_o, restart_o
  );
endinterface

// File: rtl/psum_accumulator_sat_add.sv
// sat_add: W-bit signed adder; with PSUM_ACC_SATURATE_EN it clamps to the
// signed range and flags the clamp on ovf_o, otherwise it wraps.
module sat_add #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
`ifdef PSUM_ACC_SATURATE_EN
  output logic         ovf_o,
`endif
  output logic [W-1:0] y_o
);
`ifdef PSUM_ACC_SATURATE_EN
  logic [W-1:0] raw_s;
  logic         ovf_s;

  assign raw_s = a_i + b_i;
  // Overflow only when both operands share a sign the result lacks.
  assign ovf_s = (a_i[W-1] == b_i[W-1]) && (raw_s[W-1] != a_i[W-1]);
  assign ovf_o = ovf_s;

  always_comb begin
    y_o = raw_s;
    if (ovf_s) begin
      y_o = a_i[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      y_o = raw_s;
    end
  end
`else
  assign y_o = a_i + b_i;
`endif
endmodule

// File: rtl/sign_extender.sv
// Sign-extends a two's-complement vector from IN_W to OUT_W bits.
module sign_extender #(
  parameter int IN_W  = 21,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  in_i,
  output logic [OUT_W-1:0] out_o
);
  assign out_o = {{(OUT_W-IN_W){in_i[IN_W-1]}}, in_i};
endmodule

// File: rtl/psum_accumulator.sv
// Resolves (sum, carry) pairs and accumulates them per first/last group.
// Define PSUM_ACC_SATURATE_EN for clamping arithmetic and the ovf_o flag.
module psum_accumulator
  import psum_acc_pkg::*;
#(
  parameter int IN_SIZE  = IN_SIZE_DEF,
  parameter int ACC_SIZE = ACC_SIZE_DEF,
  parameter int CNT_SIZE = CNT_SIZE_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  psum_accumulator_if.slave  bus
);
  logic [ACC_SIZE-1:0] sum_ext_s, carry_ext_s;
  logic                ready_o_s, blocked_s, in_hs_s, b_take_s;
  stage_a_t            a_d, a_q;
  logic                a_valid_d, a_valid_q;

  state_e              state_d, state_q;
  logic [ACC_SIZE-1:0] acc_d, acc_q, add_y_s;
  logic [CNT_SIZE-1:0] cnt_d, cnt_q;
  logic                valid_o_d, valid_o_q;
  logic [ACC_SIZE-1:0] acc_o_d, acc_o_q;
  logic [CNT_SIZE-1:0] cnt_o_d, cnt_o_q;
  logic                restart_d, restart_q;
  logic                start_s;
`ifdef PSUM_ACC_SATURATE_EN
  logic                add_ovf_s;
  logic                grp_ovf_d, grp_ovf_q;
  logic                ovf_o_d, ovf_o_q;
`endif

  sign_extender #(.IN_W(IN_SIZE), .OUT_W(ACC_SIZE)) u_sext_sum (
    .in_i (bus.sum_i),
    .out_o(sum_ext_s)
  );

  sign_extender #(.IN_W(IN_SIZE), .OUT_W(ACC_SIZE)) u_sext_carry (
    .in_i (bus.carry_i),
    .out_o(carry_ext_s)
  );

  sat_add #(.W(ACC_SIZE)) u_sat_add (
    .a_i  (acc_q),
    .b_i  (a_q.s),
`ifdef PSUM_ACC_SATURATE_EN
    .ovf_o(add_ovf_s),
`endif
    .y_o  (add_y_s)
  );

  // Only a closing beat can stall, and only behind an untaken result.
  assign blocked_s = a_q.last & valid_o_q & ~bus.ready_i;
  assign ready_o_s = ~a_valid_q | ~blocked_s;
  assign in_hs_s   = bus.valid_i & ready_o_s;
  assign b_take_s  = a_valid_q & ~blocked_s;

  always_comb begin
    a_d       = a_q;
    a_valid_d = a_valid_q;
    if (in_hs_s) begin
      a_d.s     = sum_ext_s + carry_ext_s;
      a_d.first = bus.first_i;
      a_d.last  = bus.last_i;
      a_valid_d = 1'b1;
    end else if (b_take_s) begin
      a_valid_d = 1'b0;
    end else begin
      a_valid_d = a_valid_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    restart_d = 1'b0;
    start_s   = 1'b1;
    valid_o_d = valid_o_q & ~bus.ready_i;
    acc_o_d   = acc_o_q;
    cnt_o_d   = cnt_o_q;
`ifdef PSUM_ACC_SATURATE_EN
    grp_ovf_d = grp_ovf_q;
    ovf_o_d   = ovf_o_q;
`endif
    if (b_take_s) begin
      case (state_q)
        IDLE:    start_s = 1'b1;
        ACCUM: begin
          start_s   = a_q.first;
          restart_d = a_q.first;
        end
        default: start_s = 1'b1;
      endcase
      if (start_s) begin
        acc_d = a_q.s;
        cnt_d = CNT_SIZE'(1);
`ifdef PSUM_ACC_SATURATE_EN
        grp_ovf_d = 1'b0;
`endif
      end else begin
        acc_d = add_y_s;
        cnt_d = cnt_q + CNT_SIZE'(1);
`ifdef PSUM_ACC_SATURATE_EN
        grp_ovf_d = grp_ovf_q | add_ovf_s;
`endif
      end
      state_d = a_q.last ? IDLE : ACCUM;
      // A new publish wins over a same-cycle ready_i.
      if (a_q.last) begin
        valid_o_d = 1'b1;
        acc_o_d   = acc_d;
        cnt_o_d   = cnt_d;
`ifdef PSUM_ACC_SATURATE_EN
        ovf_o_d   = grp_ovf_d;
`endif
      end else begin
        valid_o_d = valid_o_q & ~bus.ready_i;
      end
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q       <= '0;
      a_valid_q <= 1'b0;
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      valid_o_q <= 1'b0;
      acc_o_q   <= '0;
      cnt_o_q   <= '0;
      restart_q <= 1'b0;
`ifdef PSUM_ACC_SATURATE_EN
      grp_ovf_q <= 1'b0;
      ovf_o_q   <= 1'b0;
`endif
    end else begin
      a_q       <= a_d;
      a_valid_q <= a_valid_d;
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      valid_o_q <= valid_o_d;
      acc_o_q   <= acc_o_d;
      cnt_o_q   <= cnt_o_d;
      restart_q <= restart_d;
`ifdef PSUM_ACC_SATURATE_EN
      grp_ovf_q <= grp_ovf_d;
      ovf_o_q   <= ovf_o_d;
`endif
    end
  end

  assign bus.ready_o   = ready_o_s;
  assign bus.valid_o   = valid_o_q;
  assign bus.acc_o     = acc_o_q;
  assign bus.cnt_o     = cnt_o_q;
  assign bus.restart_o = restart_q;
`ifdef PSUM_ACC_SATURATE_EN
  assign bus.ovf_o     = ovf_o_q;
`endif
endmodule

// File: tb/tb_psum_accumulator.sv
// Scoreboard bench for psum_accumulator (wrap or PSUM_ACC_SATURATE_EN build).
module tb_psum_accumulator;
  typedef struct {
    longint acc;
    int     cnt;
    bit     ovf;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  exp_t sb[$];

  longint m_acc;
  int     m_cnt;
  bit     m_ovf;
  bit     m_open;
  int     m_restarts;
  int     restart_seen;
  longint last_acc;
  int     last_cnt;
  bit     last_ovf;
  bit     rand_ready_en;

  psum_accumulator_if #(.IN_SIZE(21), .ACC_SIZE(32), .CNT_SIZE(8)) bus ();

  psum_accumulator #(.IN_SIZE(21), .ACC_SIZE(32), .CNT_SIZE(8)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference group model, fed on each accepted beat.
  task automatic model_beat(input longint s, input bit first, input bit last);
    longint t;
    exp_t   e;
    if (!m_open || first) begin
      if (m_open) m_restarts++;
      m_acc = s;
      m_cnt = 1;
      m_ovf = 1'b0;
    end else begin
      t = m_acc + s;
`ifdef PSUM_ACC_SATURATE_EN
      if (t > 64'sd2147483647) begin
        t = 64'sd2147483647;
        m_ovf = 1'b1;
      end else if (t < -64'sd2147483648) begin
        t = -64'sd2147483648;
        m_ovf = 1'b1;
      end
`else
      t = longint'($signed(t[31:0]));
`endif
      m_acc = t;
      m_cnt = (m_cnt + 1) % 256;
    end
    m_open = !last;
    if (last) begin
      e.acc = m_acc & 64'hFFFF_FFFF;
      e.cnt = m_cnt;
      e.ovf = m_ovf;
      sb.push_back(e);
    end
  endtask

  task automatic send(input int sum_v, input int carry_v, input bit first, input bit last,
                      output int waited);
    logic [20:0] sv, cv;
    sv = sum_v[20:0];
    cv = carry_v[20:0];
    waited = 0;
    bus.valid_i = 1'b1;
    bus.sum_i   = sv;
    bus.carry_i = cv;
    bus.first_i = first;
    bus.last_i  = last;
    while (!bus.ready_o && waited < 100) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (waited >= 100) begin
      check("send_timeout", longint'(waited), 0);
    end else begin
      @(posedge clk);
      model_beat(longint'($signed(sv)) + longint'($signed(cv)), first, last);
      @(negedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    bus.valid_i = 1'b0;
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Result monitor: compares each taken result against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (bus.restart_o) restart_seen++;
        if (bus.valid_o && bus.ready_i) begin
          check("sb_avail", longint'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("acc_o", longint'(bus.acc_o), e.acc);
            check("cnt_o", longint'(bus.cnt_o), longint'(e.cnt));
`ifdef PSUM_ACC_SATURATE_EN
            check("ovf_o", longint'(bus.ovf_o), longint'(e.ovf));
            last_ovf = bus.ovf_o;
`endif
            last_acc = longint'(bus.acc_o);
            last_cnt = int'(bus.cnt_o);
          end
        end
      end
    end
  end

  // Random downstream backpressure during the random phase.
  initial begin
    forever begin
      @(negedge clk);
      if (rand_ready_en) bus.ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int w;
    int r0;
    int len;
    n_checks = 0;
    n_errors = 0;
    m_open = 1'b0;
    m_restarts = 0;
    restart_seen = 0;
    rand_ready_en = 1'b0;
    rst = 1'b1;
    bus.valid_i = 1'b0;
    bus.sum_i   = '0;
    bus.carry_i = '0;
    bus.first_i = 1'b0;
    bus.last_i  = 1'b0;
    bus.ready_i = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready_o", longint'(bus.ready_o), 1);
    check("rst_valid_o", longint'(bus.valid_o), 0);
    check("rst_acc_o", longint'(bus.acc_o), 0);
    check("rst_cnt_o", longint'(bus.cnt_o), 0);
    check("rst_restart_o", longint'(bus.restart_o), 0);
`ifdef PSUM_ACC_SATURATE_EN
    check("rst_ovf_o", longint'(bus.ovf_o), 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    #1;

    // Single beat with two-edge latency.
    send(5, -2, 1'b1, 1'b1, w);
    bus.valid_i = 1'b0;
    check("lat_k", longint'(bus.valid_o), 0);
    @(negedge clk);
    #1;
    check("lat_k1", longint'(bus.valid_o), 1);
    idle(3);
    check("single_acc", last_acc, 3);
    check("single_cnt", longint'(last_cnt), 1);

    // Back-to-back group of four.
    send(9, 1, 1'b1, 1'b0, w);   check("g4_rdy0", longint'(w), 0);
    send(21, -1, 1'b0, 1'b0, w); check("g4_rdy1", longint'(w), 0);
    send(-4, -1, 1'b0, 1'b0, w); check("g4_rdy2", longint'(w), 0);
    send(6, 1, 1'b0, 1'b1, w);   check("g4_rdy3", longint'(w), 0);
    idle(4);
    check("g4_acc", last_acc, 32);
    check("g4_cnt", longint'(last_cnt), 4);

    // Backpressure: two single-beat groups held behind ready_i=0.
    bus.ready_i = 1'b0;
    send(1, 0, 1'b1, 1'b1, w);
    send(2, 0, 1'b1, 1'b1, w);
    idle(5);
    check("bp_hold_acc", longint'(bus.acc_o), 1);
    check("bp_valid", longint'(bus.valid_o), 1);
    check("bp_ready_o", longint'(bus.ready_o), 0);
    bus.ready_i = 1'b1;
    idle(4);
    check("bp_second", last_acc, 2);
    check("bp_drained", longint'(sb.size()), 0);

    // Restart of an open group.
    r0 = restart_seen;
    send(100, 0, 1'b1, 1'b0, w);
    send(100, 0, 1'b0, 1'b0, w);
    send(4, 0, 1'b1, 1'b1, w);
    idle(4);
    check("restart_pulses", longint'(restart_seen - r0), 1);
    check("restart_acc", last_acc, 4);
    check("restart_cnt", longint'(last_cnt), 1);

    // Long group that overflows a 32-bit accumulator.
    for (int i = 0; i < 4096; i++) begin
      send(1048575, 0, (i == 0), (i == 4095), w);
    end
    idle(4);
`ifdef PSUM_ACC_SATURATE_EN
    check("ovf_acc", last_acc, 64'h7FFF_FFFF);
    check("ovf_flag", longint'(last_ovf), 1);
`else
    check("ovf_acc", last_acc, 64'hFFFF_F000);
`endif
    check("ovf_cnt", longint'(last_cnt), 0);

    // Reset mid-group with a result still pending.
    bus.ready_i = 1'b0;
    send(7, 0, 1'b1, 1'b1, w);
    send(1, 0, 1'b1, 1'b0, w);
    send(1, 0, 1'b0, 1'b0, w);
    bus.valid_i = 1'b0;
    check("pre_rst_valid", longint'(bus.valid_o), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", longint'(bus.valid_o), 0);
    check("mid_rst_acc", longint'(bus.acc_o), 0);
    check("mid_rst_ready", longint'(bus.ready_o), 1);
    sb.delete();
    m_open = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    bus.ready_i = 1'b1;
    @(negedge clk);
    #1;
    send(9, 0, 1'b0, 1'b1, w);
    idle(4);
    check("post_rst_acc", last_acc, 9);
    check("post_rst_cnt", longint'(last_cnt), 1);

    // Random groups under random backpressure.
    rand_ready_en = 1'b1;
    for (int g = 0; g < 20; g++) begin
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        send(int'($urandom), int'($urandom),
             (b == 0) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 9) == 0),
             (b == len - 1), w);
      end
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    bus.valid_i = 1'b0;
    @(negedge clk);
    rand_ready_en = 1'b0;
    bus.ready_i = 1'b1;
    for (int t = 0; t < 50 && sb.size() > 0; t++) begin
      @(negedge clk);
      #1;
    end
    idle(3);
    check("final_drain", longint'(sb.size()), 0);
    check("restart_total", longint'(restart_seen), longint'(m_restarts));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
